// File: rtl/ibex_pkg.sv
// -----------------------------------------------------------------------------
// ibex_pkg
//
// Shared types and constants for the instruction-side SRAM adapter.
//
// Contents:
//   ibex_instr_resp_t   - packed {valid, err} tag carried through the response
//                         pipeline, one per granted fetch.
//   IbexMaxMemLatency   - deepest SRAM read latency the adapter supports.
//   IbexMaxOutstanding  - largest number of granted-but-unanswered fetches.
//   ibex_clamp_cfg()    - folds a configuration value into 1..max so that an
//                         out-of-range parameter still produces a sane netlist.
// -----------------------------------------------------------------------------
package ibex_pkg;

    typedef struct packed {
        logic valid;
        logic err;
    } ibex_instr_resp_t;

    localparam int unsigned IbexMaxMemLatency  = 3;
    localparam int unsigned IbexMaxOutstanding = 3;

    function automatic int unsigned ibex_clamp_cfg(input int unsigned value,
                                                   input int unsigned max_value);
        if (value < 1) begin
            return 1;
        end
        if (value > max_value) begin
            return max_value;
        end
        return value;
    endfunction

endpackage

// File: rtl/ibex_instr_resp_pipe.sv
// -----------------------------------------------------------------------------
// ibex_instr_resp_pipe
//
// Fixed-depth shift register of {valid, err} response tags. A tag enters on the
// grant cycle and leaves exactly Depth cycles later, lining up with the SRAM
// read data of the same request. There is no stall: the consumer always accepts.
//
// Parameters:
//   Depth      - number of stages (SRAM read latency), folded into 1..3.
//
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset; clears every stage
//   in_valid   in   a request was granted this cycle
//   in_err     in   that request targets an address outside the SRAM window
//   out_valid  out  response slot valid (last stage)
//   out_err    out  response slot is an error (last stage)
// -----------------------------------------------------------------------------
module ibex_instr_resp_pipe
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid,
    input  logic in_err,
    output logic out_valid,
    output logic out_err
);

    localparam int unsigned NumStages = ibex_clamp_cfg(Depth, IbexMaxMemLatency);

    ibex_instr_resp_t stage_in;
    ibex_instr_resp_t stage_q [NumStages];

    assign stage_in.valid = in_valid;
    assign stage_in.err   = in_err;

    // One process for the whole chain; stage 0 loads the new tag and every
    // later stage takes its predecessor on each clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumStages); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= stage_in;
            for (int i = 1; i < int'(NumStages); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[NumStages-1].valid;
    assign out_err   = stage_q[NumStages-1].err;

endmodule

// File: rtl/ibex_instr_sram_adapter.sv
// -----------------------------------------------------------------------------
// ibex_instr_sram_adapter
//
// Bridges the prefetch buffer's req/gnt/rvalid fetch interface to a single-port
// fixed-latency instruction SRAM. Fetches are granted while fewer than
// MaxOutstanding are in flight; each granted fetch is answered exactly
// MemLatency cycles later, in grant order, with SRAM data or (for addresses
// outside the SRAM window) an error response with zero data.
//
// Parameters:
//   MemLatency      SRAM read latency in cycles (1..3)
//   MaxOutstanding  granted-but-unanswered limit (1..3)
//   MemBase         byte base address of the SRAM window (word aligned)
//   MemWords        SRAM depth in 32-bit words (power of two, >= 2)
//
// Ports:
//   clk_i           in   clock
//   rst_ni          in   asynchronous active-low reset
//   instr_req_i     in   fetch request
//   instr_addr_i    in   fetch byte address, bits [1:0] ignored
//   instr_gnt_o     out  request accepted this cycle (combinational)
//   instr_rvalid_o  out  one-cycle response pulse per granted request
//   instr_rdata_o   out  response data, zero unless a valid non-error response
//   instr_err_o     out  response is an error, qualified by instr_rvalid_o
//   mem_req_o       out  SRAM read enable, only with a grant to an in-range address
//   mem_addr_o      out  SRAM word address (don't-care without mem_req_o)
//   mem_rdata_i     in   SRAM read data, valid MemLatency cycles after mem_req_o
//   busy_o          out  at least one request outstanding
// -----------------------------------------------------------------------------
module ibex_instr_sram_adapter
    import ibex_pkg::*;
#(
    parameter int unsigned MemLatency     = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemWords       = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    output logic                        mem_req_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [31:0]                 mem_rdata_i,
    output logic                        busy_o
);

    localparam int unsigned AddrWidth  = $clog2(MemWords);
    localparam int unsigned PipeDepth  = ibex_clamp_cfg(MemLatency, IbexMaxMemLatency);
    localparam int unsigned OutLimit   = ibex_clamp_cfg(MaxOutstanding, IbexMaxOutstanding);
    localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(OutLimit);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // The base is word aligned, so subtracting at word granularity gives the
    // same result as off[31:2] of the full byte subtract. Anything below the
    // base wraps to a huge offset and falls out of range naturally.
    logic [29:0] off_word;
    logic        in_range;
    logic [1:0]  unused_addr_lsb;

    assign off_word        = instr_addr_i[31:2] - MemBase[31:2];
    assign in_range        = (off_word < 30'(MemWords));
    assign unused_addr_lsb = instr_addr_i[1:0];

    // ------------------------------------------------------------------
    // Grant and SRAM request
    // ------------------------------------------------------------------
    // The grant deliberately ignores a response leaving in the same cycle so
    // the grant path stays short; the cost is one bubble at the full boundary.
    logic                gnt;
    logic                resp_valid;
    logic                resp_err;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_next;

    assign gnt         = instr_req_i & (cnt_q < CntMax);
    assign instr_gnt_o = gnt;
    assign mem_req_o   = gnt & in_range;
    assign mem_addr_o  = off_word[AddrWidth-1:0];

    // ------------------------------------------------------------------
    // Outstanding counter
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_q;
        if (gnt && !resp_valid) begin
            cnt_next = cnt_q + CntWidth'(1);
        end else if (!gnt && resp_valid) begin
            cnt_next = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    assign busy_o = (cnt_q != '0);

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    // The error tag is masked with the grant so an idle cycle presenting an
    // out-of-range address never leaves a stray err bit in the pipeline.
    ibex_instr_resp_pipe #(
        .Depth (PipeDepth)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (gnt),
        .in_err    (gnt & ~in_range),
        .out_valid (resp_valid),
        .out_err   (resp_err)
    );

    assign instr_rvalid_o = resp_valid;
    assign instr_err_o    = resp_err;

    // SRAM data is only meaningful for a live, in-range response; everything
    // else returns zero so error responses never leak stale SRAM output.
    assign instr_rdata_o  = (resp_valid && !resp_err) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibex_instr_sram_adapter.sv
// -----------------------------------------------------------------------------
// tb_ibex_instr_sram_adapter
//
// Four adapter instances share clock, reset, req and addr:
//   0: MemLatency=1 MaxOutstanding=2 MemBase=0
//   1: MemLatency=2 MaxOutstanding=2 MemBase=0
//   2: MemLatency=3 MaxOutstanding=2 MemBase=0
//   3: MemLatency=2 MaxOutstanding=3 MemBase=0x1000
// Each instance has its own SRAM model: a granted word w returns
// 32'hDEAD_0000 | w after the instance latency, otherwise 32'hBAD0_BAD0.
// -----------------------------------------------------------------------------
module tb_ibex_instr_sram_adapter;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;

    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [3:0]  err;
    logic [3:0]  mreq;
    logic [3:0]  busy;
    logic [31:0] rdata  [4];
    logic [31:0] mrdata [4];
    logic [9:0]  maddr  [4];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ibex_instr_sram_adapter #(.MemLatency(1), .MaxOutstanding(2), .MemBase(32'h0), .MemWords(1024)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
        .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]), .mem_rdata_i(mrdata[0]), .busy_o(busy[0]));

    ibex_instr_sram_adapter #(.MemLatency(2), .MaxOutstanding(2), .MemBase(32'h0), .MemWords(1024)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
        .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]), .mem_rdata_i(mrdata[1]), .busy_o(busy[1]));

    ibex_instr_sram_adapter #(.MemLatency(3), .MaxOutstanding(2), .MemBase(32'h0), .MemWords(1024)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
        .mem_req_o(mreq[2]), .mem_addr_o(maddr[2]), .mem_rdata_i(mrdata[2]), .busy_o(busy[2]));

    ibex_instr_sram_adapter #(.MemLatency(2), .MaxOutstanding(3), .MemBase(32'h1000), .MemWords(1024)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[3]), .instr_rvalid_o(rvalid[3]), .instr_rdata_o(rdata[3]), .instr_err_o(err[3]),
        .mem_req_o(mreq[3]), .mem_addr_o(maddr[3]), .mem_rdata_i(mrdata[3]), .busy_o(busy[3]));

    // ------------------------------------------------------------------
    // SRAM models
    // ------------------------------------------------------------------
    function automatic int lat(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    logic [2:0] srq [4];
    logic [9:0] sra [4][3];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            srq[i]    <= {srq[i][1:0], mreq[i]};
            sra[i][0] <= maddr[i];
            sra[i][1] <= sra[i][0];
            sra[i][2] <= sra[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mrdata[i] = srq[i][lat(i)-1] ? (32'hDEAD_0000 | {22'b0, sra[i][lat(i)-1]}) : 32'hBAD0_BAD0;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a);
        @(negedge clk);
        req  = r;
        addr = a;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  inst;
        logic        req;
        logic [31:0] addr;
        logic        gnt;
        logic        mreq;
        logic [9:0]  maddr;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    vec_t vecs [22];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0]  prev_inst;
        logic [7:0]  b_gnt, b_rv, b_busy;
        logic [12:0] c_gnt, c_rv;
        int          gcount, rcount;

        rst_n = 1'b0;
        req   = 1'b0;
        addr  = 32'h0;

        //                inst  req   addr          gnt   mreq  maddr   rv    err   rdata          busy
        // instance 0: single fetch, same-cycle grant+rvalid, window edge
        vecs[0]  = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{2'd0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 10'h004, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 32'hDEAD_0004, 1'b1};
        vecs[3]  = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{2'd0, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 10'h008, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{2'd0, 1'b1, 32'h0000_0024, 1'b1, 1'b1, 10'h009, 1'b1, 1'b0, 32'hDEAD_0008, 1'b1};
        vecs[6]  = '{2'd0, 1'b1, 32'h0000_0028, 1'b1, 1'b1, 10'h00A, 1'b1, 1'b0, 32'hDEAD_0009, 1'b1};
        vecs[7]  = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 32'hDEAD_000A, 1'b1};
        vecs[8]  = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'd0, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[10] = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[11] = '{2'd0, 1'b1, 32'h0000_0FFC, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[12] = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 32'hDEAD_03FF, 1'b1};
        // instance 3: MemBase 0x1000 address decode
        vecs[13] = '{2'd3, 1'b1, 32'h0000_0FFC, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[14] = '{2'd3, 1'b1, 32'h0000_1FFC, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[15] = '{2'd3, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[16] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 32'hDEAD_03FF, 1'b1};
        vecs[17] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[18] = '{2'd3, 1'b1, 32'h0000_1000, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[19] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[20] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 32'hDEAD_0000, 1'b1};
        vecs[21] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0000, 1'b0};

        prev_inst = 2'd0;
        for (int i = 0; i < 22; i++) begin
            if (i == 0 || vecs[i].inst != prev_inst) begin
                do_reset();
            end
            prev_inst = vecs[i].inst;
            drive(vecs[i].req, vecs[i].addr);
            $display("[TB] vec %0d inst %0d req=%b addr=%h gnt=%b mreq=%b rvalid=%b err=%b rdata=%h busy=%b",
                     i, vecs[i].inst, req, addr, gnt[vecs[i].inst], mreq[vecs[i].inst],
                     rvalid[vecs[i].inst], err[vecs[i].inst], rdata[vecs[i].inst], busy[vecs[i].inst]);
            chk($sformatf("vec%0d_gnt", i),    32'(gnt[vecs[i].inst]),    32'(vecs[i].gnt));
            chk($sformatf("vec%0d_mreq", i),   32'(mreq[vecs[i].inst]),   32'(vecs[i].mreq));
            if (vecs[i].mreq)
                chk($sformatf("vec%0d_maddr", i), 32'(maddr[vecs[i].inst]), 32'(vecs[i].maddr));
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid[vecs[i].inst]), 32'(vecs[i].rv));
            if (vecs[i].rv)
                chk($sformatf("vec%0d_err", i), 32'(err[vecs[i].inst]), 32'(vecs[i].err));
            chk($sformatf("vec%0d_rdata", i),  rdata[vecs[i].inst],       vecs[i].rdata);
            chk($sformatf("vec%0d_busy", i),   32'(busy[vecs[i].inst]),   32'(vecs[i].busy));
        end

        // --------------------------------------------------------------
        // Back-to-back, latency 2, MaxOutstanding 2 (instance 1).
        // Full at cycle 2 (two grants, no credit for the rvalid leaving).
        // --------------------------------------------------------------
        do_reset();
        b_gnt  = 8'h1B;   // cycles 0,1,3,4
        b_rv   = 8'h6C;   // cycles 2,3,5,6
        b_busy = 8'h7E;   // cycles 1..6
        gcount = 0;
        rcount = 0;
        for (int c = 0; c < 8; c++) begin
            drive(c < 5, 32'(gcount * 4));
            $display("[TB] b2b cycle %0d req=%b addr=%h gnt=%b rvalid=%b rdata=%h busy=%b",
                     c, req, addr, gnt[1], rvalid[1], rdata[1], busy[1]);
            chk($sformatf("b2b_c%0d_gnt", c),  32'(gnt[1]),  32'(b_gnt[c]));
            chk($sformatf("b2b_c%0d_mreq", c), 32'(mreq[1]), 32'(b_gnt[c]));
            if (b_gnt[c]) begin
                chk($sformatf("b2b_c%0d_maddr", c), 32'(maddr[1]), 32'(gcount));
                gcount++;
            end
            chk($sformatf("b2b_c%0d_rvalid", c), 32'(rvalid[1]), 32'(b_rv[c]));
            if (b_rv[c]) begin
                chk($sformatf("b2b_c%0d_rdata", c), rdata[1], 32'hDEAD_0000 + 32'(rcount));
                rcount++;
            end
            chk($sformatf("b2b_c%0d_busy", c), 32'(busy[1]), 32'(b_busy[c]));
        end

        // --------------------------------------------------------------
        // Saturation, latency 3, MaxOutstanding 2 (instance 2).
        // Request held for cycles 0..8, then drained.
        // --------------------------------------------------------------
        do_reset();
        c_gnt  = 13'h133;  // cycles 0,1,4,5,8
        c_rv   = 13'h998;  // cycles 3,4,7,8,11
        gcount = 0;
        rcount = 0;
        for (int c = 0; c < 13; c++) begin
            drive(c < 9, 32'(gcount * 4));
            $display("[TB] sat cycle %0d req=%b addr=%h gnt=%b rvalid=%b rdata=%h busy=%b",
                     c, req, addr, gnt[2], rvalid[2], rdata[2], busy[2]);
            chk($sformatf("sat_c%0d_gnt", c),    32'(gnt[2]),    32'(c_gnt[c]));
            chk($sformatf("sat_c%0d_rvalid", c), 32'(rvalid[2]), 32'(c_rv[c]));
            if (c_gnt[c]) gcount++;
            if (c_rv[c]) begin
                chk($sformatf("sat_c%0d_rdata", c), rdata[2], 32'hDEAD_0000 + 32'(rcount));
                rcount++;
            end
            chk($sformatf("sat_c%0d_busy", c), 32'(busy[2]), (c >= 1 && c <= 11) ? 32'd1 : 32'd0);
        end

        // --------------------------------------------------------------
        // Reset mid-flight, latency 2 (instance 1).
        // --------------------------------------------------------------
        do_reset();
        drive(1'b1, 32'h40);
        chk("rst_g0_gnt", 32'(gnt[1]), 32'd1);
        drive(1'b1, 32'h44);
        chk("rst_g1_gnt", 32'(gnt[1]), 32'd1);
        @(negedge clk);
        // first response is already on the bus before reset drops
        chk("rst_pre_rvalid", 32'(rvalid[1]), 32'd1);
        chk("rst_pre_rdata",  rdata[1], 32'hDEAD_0010);
        rst_n = 1'b0;
        req   = 1'b1;
        addr  = 32'h48;
        #1;
        $display("[TB] reset asserted: gnt=%b rvalid=%b err=%b busy=%b", gnt[1], rvalid[1], err[1], busy[1]);
        chk("rst_in_rvalid", 32'(rvalid[1]), 32'd0);
        chk("rst_in_err",    32'(err[1]),    32'd0);
        chk("rst_in_busy",   32'(busy[1]),   32'd0);
        chk("rst_in_rdata",  rdata[1],       32'h0);
        chk("rst_in_gnt",    32'(gnt[1]),    32'd1);
        drive(1'b0, 32'h0);
        chk("rst_hold_rvalid", 32'(rvalid[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_rvalid", 32'(rvalid[1]), 32'd0);
        chk("rst_rel_rdata",  rdata[1],       32'h0);
        chk("rst_rel_busy",   32'(busy[1]),   32'd0);
        drive(1'b1, 32'h50);
        $display("[TB] fresh request after reset: gnt=%b maddr=%h busy=%b", gnt[1], maddr[1], busy[1]);
        chk("rst_new_gnt",    32'(gnt[1]),   32'd1);
        chk("rst_new_maddr",  32'(maddr[1]), 32'h14);
        chk("rst_new_rvalid", 32'(rvalid[1]), 32'd0);
        drive(1'b0, 32'h0);
        chk("rst_new_p1_rvalid", 32'(rvalid[1]), 32'd0);
        chk("rst_new_p1_busy",   32'(busy[1]),   32'd1);
        drive(1'b0, 32'h0);
        chk("rst_new_p2_rvalid", 32'(rvalid[1]), 32'd1);
        chk("rst_new_p2_rdata",  rdata[1],       32'hDEAD_0014);
        drive(1'b0, 32'h0);
        chk("rst_new_p3_rvalid", 32'(rvalid[1]), 32'd0);
        chk("rst_new_p3_busy",   32'(busy[1]),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
